fifo_wr_ctrl: RTL and testbench

Write-side controller of the asynchronous FIFO, clocked entirely in the write domain. It sits directly upstream of the dual-clock RAM block. It accepts producer write requests, generates the RAM write enable, address and data, and maintains the binary and Gray write pointers. It synchronizes the read-domain Gray pointer and derives full, almost-full, occupancy and overflow status.

---
 rtl/fifo_wr_ctrl_pkg.sv | 18 +
 rtl/fifo_wr_ctrl_sync.sv | 21 ++
 rtl/fifo_wr_ctrl.sv | 77 +++++++
 tb/tb_fifo_wr_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// fifo_wr_ctrl_pkg: pointer-width and Gray-code helpers shared by the async FIFO blocks
package fifo_wr_ctrl_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_ctrl_sync.sv
// gray_ptr_sync: two-flop synchronizer for a Gray-coded pointer crossing clock domains
module gray_ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q1, r_q2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end
  assign o_q = r_q2;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side controller; drives RAM writes and derives full/occupancy status
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [AW:0]           rd_ptr_gray,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [AW:0]           wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [AW:0]           wr_count,
  output logic                  overflow
);
  logic [AW:0]           r_wbin, r_gray, r_count;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en, r_full, r_af, r_ovf;
  logic [AW:0]           w_rq2, w_wbin_next, w_wgray_next, w_count_next, w_free_next;
  logic                  w_accept, w_full_next, w_af_next;
  gray_ptr_sync #(.WIDTH(AW + 1)) u_rd_sync (
    .clk(wr_clk),
    .rst(wr_rst),
    .i_d(rd_ptr_gray),
    .o_q(w_rq2)
  );
  // acceptance uses only the registered full, never a look-ahead of the read pointer
  assign w_accept     = wr_req & ~r_full;
  assign w_wbin_next  = r_wbin + (AW + 1)'(w_accept);
  assign w_wgray_next = (AW + 1)'(bin2gray(32'(w_wbin_next)));
  assign w_full_next  = w_wgray_next == {~w_rq2[AW:AW-1], w_rq2[AW-2:0]};
  assign w_count_next = w_wbin_next - (AW + 1)'(gray2bin(32'(w_rq2)));
  assign w_free_next  = (AW + 1)'(DEPTH) - w_count_next;
  assign w_af_next    = w_free_next <= (AW + 1)'(AF_MARGIN);
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_wbin  <= '0;
      r_gray  <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_gray  <= w_wgray_next;
      r_en    <= w_accept;
      if (w_accept) begin
        r_addr <= r_wbin[AW-1:0];
        r_data <= wr_din;
      end
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_count <= w_count_next;
      r_ovf   <= r_ovf | (wr_req & r_full);
    end
  end
  assign mem_wr_en   = r_en;
  assign mem_wr_addr = r_addr;
  assign mem_wr_data = r_data;
  assign wr_ptr_gray = r_gray;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wr_count    = r_count;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: scoreboard bench with an occupancy-level reference model of the write controller
module tb_fifo_wr_ctrl;
  localparam int DW = 8, D = 8, AFM = 2, AW = 3;
  logic          wr_clk = 0, wr_rst = 1, wr_req = 0;
  logic [DW-1:0] wr_din = 0;
  logic [AW:0]   rd_ptr_gray = 0;
  logic          mem_wr_en, full, almost_full, overflow;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [AW:0]   wr_ptr_gray, wr_count;
  fifo_wr_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .AF_MARGIN(AFM)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_req(wr_req), .wr_din(wr_din),
    .rd_ptr_gray(rd_ptr_gray), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .wr_ptr_gray(wr_ptr_gray), .full(full),
    .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow)
  );
  always #5 wr_clk = ~wr_clk;
  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_w = 0, m_rq1 = 0, m_rq2 = 0, m_cnt = 0, rd = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  logic [AW:0] prev_g = 0;
  function automatic int g4(input int v);
    int b;
    b = v & 15;
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  // one clock: drive at negedge, update the model at posedge, compare status at the next negedge
  task automatic step(input bit rst, input bit req, input int rdv, input logic [DW-1:0] din);
    wr_rst = rst; wr_req = req; wr_din = din; rd_ptr_gray = 4'(g4(rdv));
    @(posedge wr_clk);
    cyc++;
    if (rst) begin
      m_w = 0; m_rq1 = 0; m_rq2 = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      if (req && m_full) m_ovf = 1;
      if (req && !m_full) begin
        exp_q.push_back('{cyc, m_w & 7, int'(din)});
        m_w++;
      end
      m_cnt = (m_w - m_rq2) & 15;
      m_full = m_cnt == D;
      m_af = (D - m_cnt) <= AFM;
      m_rq2 = m_rq1;
      m_rq1 = rdv;
    end
    @(negedge wr_clk);
    chk("full", full, m_full);
    chk("almost_full", almost_full, m_af);
    chk("wr_count", wr_count, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("wr_ptr_gray", wr_ptr_gray, g4(m_w));
    if (!rst) chk("gray_one_bit", $countones(wr_ptr_gray ^ prev_g) <= 1, 1);
    prev_g = wr_ptr_gray;
  endtask
  always @(negedge wr_clk) begin
    if (mem_wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", mem_wr_addr, e.addr);
        chk("wr_data", mem_wr_data, e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("missing_write", 0, 1);
      void'(exp_q.pop_front());
    end
  end
  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_en", mem_wr_en, 0);
    chk("rst_addr", mem_wr_addr, 0);
    chk("rst_data", mem_wr_data, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'($urandom));
      if (i == 4) chk("af_after5", almost_full, 0);
      if (i == 5) chk("af_after6", almost_full, 1);
      if (i == 6) chk("full_after7", full, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_gray", wr_ptr_gray, 4'b1100);
    chk("fill_count", wr_count, 8);
    step(0, 1, 0, 8'hA5);
    chk("ovf_set", overflow, 1);
    chk("ovf_ptr", wr_ptr_gray, 4'b1100);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("ovf_sticky", overflow, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("rel_not_early", full, 1);
    step(0, 1, 1, 8'h3C);
    chk("rel_full", full, 0);
    chk("rel_count", wr_count, 7);
    step(0, 1, 1, 8'h5A);
    step(1, 0, 0, 0);
    chk("rst_ovf_clear", overflow, 0);
    rd = 0;
    for (int i = 0; i < 20; i++) begin
      rd = (m_w >= 2) ? m_w - 2 : 0;
      step(0, 1, rd, 8'($urandom));
      chk("wrap_never_full", full, 0);
      if (i == 15) chk("wrap_gray16", wr_ptr_gray, 0);
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    step(1, 1, 0, 8'hFF);
    chk("mid_rst_en", mem_wr_en, 0);
    chk("mid_rst_addr", mem_wr_addr, 0);
    chk("mid_rst_data", mem_wr_data, 0);
    chk("mid_rst_gray", wr_ptr_gray, 0);
    chk("mid_rst_count", wr_count, 0);
    step(0, 1, 0, 8'h77);
    for (int i = 0; i < 12; i++) step(0, (i % 3) != 2, 0, 8'($urandom));
    step(1, 0, 0, 0);
    rd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rd = 0;
        step(1, $urandom_range(0, 1) == 1, 0, 8'($urandom));
      end else begin
        if ($urandom_range(0, 2) == 0 && rd < m_w) rd++;
        step(0, $urandom_range(0, 3) != 0, rd, 8'($urandom));
      end
    end
    step(0, 0, rd, 0);
    step(0, 0, rd, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
